sd_image_load_sequencer: RTL and testbench
==========================================

Name: sd_image_load_sequencer

Overview:
- Sequences multi-block SD card reads that load one 320x240 12-bit image from the card into the frame buffer write port.
- Runs in the 50 MHz SD domain, between sd_controller (block read handshake) and frame_buffer_12bit port A.
- Maps each selected image index to a block range, packs 2 bytes into each pixel, and writes pixels in raster order.
- Retries blocks that time out or end short, and aborts cleanly at a block boundary when the selection changes.

Parameters:
- IMG_PIXELS, 76800, pixels per image (320*240).
- BLOCKS_PER_IMG, 300, 512-byte blocks per image (2 bytes/pixel).
- BASE_BLOCK, 0, SD block address of image slot 0.
- IMG_STRIDE, 512, block distance between consecutive image slots.
- TIMEOUT_CYC, 1000000, cycles without progress before a block attempt fails.
- MAX_RETRY, 3, retries allowed per block before error.

Ports:
- clk  in  1  50 MHz clock.
- reset  in  1  asynchronous, active-low reset.
- image_select  in  4  requested image index; from another clock domain.
- sd_read_block  out  1  one-cycle block read request.
- sd_block_addr  out  32  block address; held stable from request until block end.
- sd_busy  in  1  controller busy; rise = request accepted, fall = block finished.
- sd_data_in  in  8  read byte.
- sd_data_valid  in  1  byte strobe, one cycle per byte.
- fb_write_en  out  1  pixel write strobe.
- fb_write_addr  out  17  pixel index, 0..IMG_PIXELS-1.
- fb_write_data  out  12  {R,G,B} 4 bits each.
- loading  out  1  high while a load is in progress.
- load_done  out  1  high after a complete load; cleared when the next load starts.
- load_error  out  1  high after retry exhaustion; cleared when the next load starts.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM=IDLE, pending=1 so image_select is loaded after reset is released.
- image_select passes through a 2-flop synchronizer. A synchronized value different from cur_sel sets pending.
- States and transitions:
  - IDLE: if pending, latch cur_sel, clear pending, blk=0, pix=0, retry=0, loading=1, clear done/error -> WAIT_READY.
  - WAIT_READY: wait for sd_busy=0 -> ISSUE.
  - ISSUE: sd_read_block=1 for exactly 1 cycle; sd_block_addr = BASE_BLOCK + cur_sel*IMG_STRIDE + blk (32-bit, no wrap checks) -> WAIT_ACCEPT.
  - WAIT_ACCEPT: on sd_busy=1 -> RECEIVE, byte count=0, timer=0. Timeout -> FAIL.
  - RECEIVE: on each sd_data_valid, increment the byte counter. Even byte goes to lo. Odd byte goes to hi, then on the next cycle fb_write_en=1 with data {hi[3:0], lo[7:0]} and addr=pix, then pix++. hi[7:4] is discarded. Bytes after the 512th are ignored. Any valid byte clears the timer.
    - sd_busy=0 with count=512 -> NEXT.
    - sd_busy=0 with count<512, or timeout -> FAIL.
  - FAIL: retry++. pix rewinds to blk*256. If retry>MAX_RETRY -> ERROR, else WAIT_READY with the same blk.
  - NEXT: blk++, retry=0.
    - pending=1 -> IDLE (abort; partial image remains in buffer).
    - blk==BLOCKS_PER_IMG -> DONE.
    - otherwise -> WAIT_READY.
  - DONE: loading=0, load_done=1 -> IDLE.
  - ERROR: loading=0, load_error=1 -> IDLE. An error does not auto-retry; a selection change restarts the load.
- Timer: counts cycles in WAIT_ACCEPT and RECEIVE. Expires at TIMEOUT_CYC-1.
- Writes are suppressed when pix>=IMG_PIXELS, as a guard against an inconsistent parameter set.
- Selection changes mid-block never truncate the SD transaction; the abort occurs only in NEXT.
- Selection returning to cur_sel before NEXT: pending stays set, and the image reloads from block 0.
- Latency: last byte of a block to ISSUE of the next block is 3 cycles when sd_busy is already low.

Test Plan:
- Release reset with image_select=0. Model returns 300 blocks of pattern byte=i[7:0] -> addresses 0..299 issued in order; 76800 writes; pixel 0 data=0x100; load_done=1; loading=0.
- image_select=2 -> first sd_block_addr=1024, last=1323; fb_write_addr 0..76799 contiguous, with no duplicate or missing writes.
- Model withholds sd_busy on block 5 once -> timeout; ISSUE repeated with addr 5; pix restarts at 1280; load completes with load_done=1.
- Model ends block 7 after 100 bytes on every attempt -> 4 attempts, then load_error=1; loading=0; no writes beyond pix 1792+49.
- Change image_select 0->1 during block 10 -> block 10 finishes (writes to pix 2815); next ISSUE addr=512; pix restarts at 0.
- Assert reset low during RECEIVE -> all outputs 0 immediately; after release, reload begins at block 0 of the current selection.

Source files
------------

// File: rtl/sd_image_load_sequencer.sv
// Loads one image from the SD card into the frame buffer, one 512-byte block at a time.
// Each image index maps to a block range. Every two bytes form one 12-bit pixel, and pixels
// are written in raster order. A block that times out or ends short is retried. A change of
// selection aborts the load, but only at a block boundary.
module sd_image_load_sequencer #(
  parameter int unsigned IMG_PIXELS     = 76800,
  parameter int unsigned BLOCKS_PER_IMG = 300,
  parameter int unsigned BASE_BLOCK     = 0,
  parameter int unsigned IMG_STRIDE     = 512,
  parameter int unsigned TIMEOUT_CYC    = 1000000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  image_select,
  output logic        sd_read_block,
  output logic [31:0] sd_block_addr,
  input  logic        sd_busy,
  input  logic [7:0]  sd_data_in,
  input  logic        sd_data_valid,
  output logic        fb_write_en,
  output logic [16:0] fb_write_addr,
  output logic [11:0] fb_write_data,
  output logic        loading,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned BlkW = $clog2(BLOCKS_PER_IMG + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC);
  localparam int unsigned RtyW = $clog2(MAX_RETRY + 2);
  localparam int unsigned PixW = 17;

  localparam logic [9:0]      BlockBytes = 10'd512;
  localparam logic [TmrW-1:0] TmrLast    = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [BlkW-1:0] BlkLast    = BlkW'(BLOCKS_PER_IMG);
  localparam logic [RtyW-1:0] RtyMax     = RtyW'(MAX_RETRY);

  typedef enum logic [3:0] {
    StIdle,
    StWaitReady,
    StIssue,
    StWaitAccept,
    StReceive,
    StFail,
    StNext,
    StDone,
    StError
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      sel_meta_q, sel_sync_q;
  logic [1:0]      sync_vld_q;
  logic [3:0]      cur_sel_q, cur_sel_d;
  logic            pending_q, pending_d;
  logic [BlkW-1:0] blk_q, blk_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [RtyW-1:0] retry_q, retry_d;
  logic [9:0]      byte_cnt_q, byte_cnt_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [7:0]      lo_q, lo_d;
  logic [31:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [16:0]     waddr_q, waddr_d;
  logic [11:0]     wdata_q, wdata_d;
  logic            loading_q, loading_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  // Two-flop synchronizer for the selection. sync_vld_q holds off the first latch until
  // the synchronizer has filled with the real input value after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_meta_q <= 4'd0;
      sel_sync_q <= 4'd0;
      sync_vld_q <= 2'b00;
    end else begin
      sel_meta_q <= image_select;
      sel_sync_q <= sel_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cur_sel_q  <= 4'd0;
      pending_q  <= 1'b1;
      blk_q      <= '0;
      pix_q      <= '0;
      retry_q    <= '0;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      lo_q       <= 8'd0;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      waddr_q    <= 17'd0;
      wdata_q    <= 12'd0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      pending_q  <= pending_d;
      blk_q      <= blk_d;
      pix_q      <= pix_d;
      retry_q    <= retry_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
      lo_q       <= lo_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      loading_q  <= loading_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic for the block sequencing, retry and pixel packing.
  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    // Sticky: a selection that returns to cur_sel before the next block boundary still
    // forces a reload.
    pending_d  = pending_q | (sel_sync_q != cur_sel_q);
    blk_d      = blk_q;
    pix_d      = pix_q;
    retry_d    = retry_q;
    byte_cnt_d = byte_cnt_q;
    timer_d    = timer_q;
    lo_d       = lo_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    loading_d  = loading_q;
    done_d     = done_q;
    error_d    = error_q;

    unique case (state_q)
      StIdle: begin
        if (pending_q && sync_vld_q[1]) begin
          cur_sel_d = sel_sync_q;
          pending_d = 1'b0;
          blk_d     = '0;
          pix_d     = '0;
          retry_d   = '0;
          loading_d = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          state_d   = StWaitReady;
        end
      end
      StWaitReady: begin
        if (!sd_busy) begin
          addr_d  = BASE_BLOCK + 32'(cur_sel_q) * IMG_STRIDE + 32'(blk_q);
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWaitAccept;
      end
      StWaitAccept: begin
        if (sd_busy) begin
          byte_cnt_d = '0;
          timer_d    = '0;
          state_d    = StReceive;
        end else if (timer_q == TmrLast) begin
          state_d = StFail;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StReceive: begin
        timer_d = timer_q + TmrW'(1);
        if (sd_data_valid) begin
          timer_d = '0;
          if (byte_cnt_q < BlockBytes) begin
            byte_cnt_d = byte_cnt_q + 10'd1;
            if (!byte_cnt_q[0]) begin
              lo_d = sd_data_in;
            end else begin
              // Registered write: the strobe appears on the cycle after the odd byte.
              if (32'(pix_q) < IMG_PIXELS) begin
                we_d    = 1'b1;
                waddr_d = pix_q;
                wdata_d = {sd_data_in[3:0], lo_q};
              end
              pix_d = pix_q + PixW'(1);
            end
          end
        end
        // byte_cnt_d counts a final byte that arrives in the same cycle as busy falling.
        if (!sd_busy) begin
          state_d = (byte_cnt_d == BlockBytes) ? StNext : StFail;
        end else if (!sd_data_valid && timer_q == TmrLast) begin
          state_d = StFail;
        end
      end
      StFail: begin
        retry_d = retry_q + RtyW'(1);
        pix_d   = PixW'({blk_q, 8'h00});
        state_d = (retry_d > RtyMax) ? StError : StWaitReady;
      end
      StNext: begin
        blk_d   = blk_q + BlkW'(1);
        retry_d = '0;
        if (pending_q) begin
          state_d = StIdle;
        end else if (blk_d == BlkLast) begin
          state_d = StDone;
        end else begin
          state_d = StWaitReady;
        end
      end
      StDone: begin
        loading_d = 1'b0;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      StError: begin
        loading_d = 1'b0;
        error_d   = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign sd_read_block = (state_q == StIssue);
  assign sd_block_addr = addr_q;
  assign fb_write_en   = we_q;
  assign fb_write_addr = waddr_q;
  assign fb_write_data = wdata_q;
  assign loading       = loading_q;
  assign load_done     = done_q;
  assign load_error    = error_q;

endmodule

// File: tb/tb_sd_image_load_sequencer.sv
// Bench for sd_image_load_sequencer. It uses a reduced image of 12 blocks and a short timeout.
// A model of the SD controller answers each read request. As it sends the bytes, it pushes
// the expected frame-buffer writes into a queue. Each test pushes the expected request
// addresses. Monitors pop these queues and compare them with what the DUT presents.
module tb_sd_image_load_sequencer;

  localparam int unsigned Blocks = 12;
  localparam int unsigned Pix    = Blocks * 256;
  localparam int unsigned Tmo    = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  image_select;
  logic        sd_read_block;
  logic [31:0] sd_block_addr;
  logic        sd_busy;
  logic [7:0]  sd_data_in;
  logic        sd_data_valid;
  logic        fb_write_en;
  logic [16:0] fb_write_addr;
  logic [11:0] fb_write_data;
  logic        loading;
  logic        load_done;
  logic        load_error;

  sd_image_load_sequencer #(
    .IMG_PIXELS     (Pix),
    .BLOCKS_PER_IMG (Blocks),
    .BASE_BLOCK     (0),
    .IMG_STRIDE     (512),
    .TIMEOUT_CYC    (Tmo),
    .MAX_RETRY      (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .image_select  (image_select),
    .sd_read_block (sd_read_block),
    .sd_block_addr (sd_block_addr),
    .sd_busy       (sd_busy),
    .sd_data_in    (sd_data_in),
    .sd_data_valid (sd_data_valid),
    .fb_write_en   (fb_write_en),
    .fb_write_addr (fb_write_addr),
    .fb_write_data (fb_write_data),
    .loading       (loading),
    .load_done     (load_done),
    .load_error    (load_error)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [11:0] pix0_data = 12'd0;

  logic [16:0] exp_waddr_q[$];
  logic [11:0] exp_wdata_q[$];
  logic [31:0] exp_iss_q[$];

  // Controls for the SD model, written only by the test sequence.
  logic        withhold_en = 1'b0;
  logic [31:0] withhold_addr = 32'd0;
  logic [31:0] short_addr = 32'hffff_ffff;
  int          short_len = 512;
  // Written only by the SD model.
  logic        withhold_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor.
  always @(negedge clk) begin
    if (fb_write_en) begin
      wr_cnt++;
      if (fb_write_addr == 17'd0) pix0_data = fb_write_data;
      if (exp_waddr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL write: unexpected write addr %0d data 0x%0h, none expected",
                 fb_write_addr, fb_write_data);
      end else begin
        logic [16:0] ea;
        logic [11:0] ed;
        ea = exp_waddr_q.pop_front();
        ed = exp_wdata_q.pop_front();
        chk("write addr", 32'(fb_write_addr), 32'(ea));
        chk("write data", 32'(fb_write_data), 32'(ed));
      end
    end
  end

  // Request monitor.
  always @(negedge clk) begin
    if (sd_read_block) begin
      if (exp_iss_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL issue: unexpected request addr %0d, none expected", sd_block_addr);
      end else begin
        logic [31:0] ea;
        ea = exp_iss_q.pop_front();
        chk("issue addr", sd_block_addr, ea);
      end
    end
  end

  // SD controller model: byte i of block b is (i + b) mod 256, where b = addr mod 512.
  initial begin : sd_model
    logic [31:0] a;
    logic [7:0]  by;
    logic [7:0]  lo_b;
    int          n;
    int          pbase;
    sd_busy = 1'b0;
    sd_data_valid = 1'b0;
    sd_data_in = 8'd0;
    lo_b = 8'd0;
    forever begin
      @(negedge clk);
      if (reset && sd_read_block) begin
        a = sd_block_addr;
        if (withhold_en && !withhold_done && a == withhold_addr) begin
          withhold_done = 1'b1;
        end else begin
          n = (a == short_addr) ? short_len : 512;
          pbase = int'(a & 32'h1ff) * 256;
          repeat (2) @(posedge clk);
          #1 sd_busy = 1'b1;
          for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (!reset) break;
            by = 8'(i + int'(a & 32'h1ff));
            sd_data_valid = 1'b1;
            sd_data_in = by;
            if (i % 2 == 0) begin
              lo_b = by;
            end else if (pbase + i / 2 < int'(Pix)) begin
              exp_waddr_q.push_back(17'(pbase + i / 2));
              exp_wdata_q.push_back({by[3:0], lo_b});
            end
          end
          if (reset) begin
            @(posedge clk);
            #1;
          end
          sd_data_valid = 1'b0;
          sd_busy = 1'b0;
        end
      end
    end
  end

  task automatic push_range(input int base, input int first, input int last);
    for (int b = first; b <= last; b++) exp_iss_q.push_back(32'(base + b));
  endtask

  task automatic wait_end(input string name);
    int c = 0;
    while (!(!loading && (load_done || load_error)) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(c < 20000), 32'd1);
  endtask

  task automatic wait_issue(input logic [31:0] addr, input string name);
    int c = 0;
    while (!(sd_read_block && sd_block_addr == addr) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(c < 20000), 32'd1);
  endtask

  task automatic start_sel(input logic [3:0] sel, input string name);
    image_select = sel;
    repeat (8) @(negedge clk);
    chk({name, " loading"}, 32'(loading), 32'd1);
    chk({name, " done cleared"}, 32'(load_done), 32'd0);
    chk({name, " error cleared"}, 32'(load_error), 32'd0);
  endtask

  task automatic queues_empty(input string name);
    chk({name, " pending writes"}, exp_waddr_q.size(), 32'd0);
    chk({name, " pending issues"}, exp_iss_q.size(), 32'd0);
  endtask

  initial begin : test_seq
    int wr_base;
    reset = 1'b0;
    image_select = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst read_block", 32'(sd_read_block), 32'd0);
    chk("rst block_addr", sd_block_addr, 32'd0);
    chk("rst write_en", 32'(fb_write_en), 32'd0);
    chk("rst write_addr", 32'(fb_write_addr), 32'd0);
    chk("rst write_data", 32'(fb_write_data), 32'd0);
    chk("rst loading", 32'(loading), 32'd0);
    chk("rst load_done", 32'(load_done), 32'd0);
    chk("rst load_error", 32'(load_error), 32'd0);

    // Initial load of image 0 after reset release.
    push_range(0, 0, Blocks - 1);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("t1 loading", 32'(loading), 32'd1);
    wait_end("t1 finish");
    chk("t1 done", 32'(load_done), 32'd1);
    chk("t1 loading low", 32'(loading), 32'd0);
    chk("t1 error", 32'(load_error), 32'd0);
    chk("t1 pixel0", 32'(pix0_data), 32'h100);
    chk("t1 write count", wr_cnt, Pix);
    queues_empty("t1");

    // Image 2: blocks 1024..1035, full contiguous pixel range.
    wr_base = wr_cnt;
    push_range(1024, 0, Blocks - 1);
    start_sel(4'd2, "t2");
    wait_end("t2 finish");
    chk("t2 done", 32'(load_done), 32'd1);
    chk("t2 write count", wr_cnt - wr_base, Pix);
    queues_empty("t2");

    // Block 5 of image 0 is not accepted once, so it times out and is re-issued.
    withhold_addr = 32'd5;
    withhold_en = 1'b1;
    push_range(0, 0, 5);
    push_range(0, 5, Blocks - 1);
    start_sel(4'd0, "t3");
    wait_end("t3 finish");
    chk("t3 withheld", 32'(withhold_done), 32'd1);
    chk("t3 done", 32'(load_done), 32'd1);
    chk("t3 error", 32'(load_error), 32'd0);
    queues_empty("t3");
    withhold_en = 1'b0;

    // Block 7 of image 3 always ends after 100 bytes: four attempts, then error.
    short_addr = 32'd1536 + 32'd7;
    short_len = 100;
    push_range(1536, 0, 7);
    push_range(1536, 7, 7);
    push_range(1536, 7, 7);
    push_range(1536, 7, 7);
    start_sel(4'd3, "t4");
    wait_end("t4 finish");
    chk("t4 error", 32'(load_error), 32'd1);
    chk("t4 done", 32'(load_done), 32'd0);
    chk("t4 loading", 32'(loading), 32'd0);
    queues_empty("t4");
    short_addr = 32'hffff_ffff;
    short_len = 512;

    // Switch 0 -> 1 during block 10: block 10 completes, then image 1 loads from block 0.
    push_range(0, 0, 10);
    push_range(512, 0, Blocks - 1);
    start_sel(4'd0, "t5");
    wait_issue(32'd10, "t5 reach block 10");
    repeat (100) @(negedge clk);
    image_select = 4'd1;
    wait_end("t5 finish");
    chk("t5 done", 32'(load_done), 32'd1);
    queues_empty("t5");

    // Reset asserted while receiving block 2 of image 2.
    push_range(1024, 0, Blocks - 1);
    start_sel(4'd2, "t6");
    wait_issue(32'd1026, "t6 reach block 2");
    repeat (50) @(negedge clk);
    reset = 1'b0;
    exp_waddr_q.delete();
    exp_wdata_q.delete();
    exp_iss_q.delete();
    #1;
    chk("t6 rst read_block", 32'(sd_read_block), 32'd0);
    chk("t6 rst block_addr", sd_block_addr, 32'd0);
    chk("t6 rst write_en", 32'(fb_write_en), 32'd0);
    chk("t6 rst write_addr", 32'(fb_write_addr), 32'd0);
    chk("t6 rst loading", 32'(loading), 32'd0);
    repeat (3) @(negedge clk);
    push_range(1024, 0, Blocks - 1);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6 reload loading", 32'(loading), 32'd1);
    wait_end("t6 finish");
    chk("t6 done", 32'(load_done), 32'd1);
    queues_empty("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
